// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the retirement trace recorder.
package trace_pkg;
  localparam int STAMP_W = 32;
  localparam int DEFAULT_XLEN = 32;
  typedef enum logic {
    KIND_REG = 1'b0,
    KIND_MEM = 1'b1
  } kind_e;
  typedef struct packed {
    kind_e                   kind;
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] key;
    logic [DEFAULT_XLEN-1:0] data;
    logic [STAMP_W-1:0]      stamp;
  } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular buffer with two ordered push ports and one pop port.
module trace_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = trace_pkg::trace_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0,
  input  T                       d0,
  input  logic                   push1,
  input  T                       d1,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_wp1;
  T              r_mem [DEPTH];
  // port 1 lands right behind port 0 so a lone port-1 push does not leave a hole
  assign w_wp1 = r_wp + AW'(push0);
  assign head  = r_mem[r_rp];
  assign count = r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(push0) + AW'(push1);
      r_rp  <= r_rp + AW'(pop);
      r_cnt <= r_cnt + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push0) r_mem[r_wp] <= d0;
    if (push1) r_mem[w_wp1] <= d1;
  end
endmodule

// File: rtl/trace_recorder.sv
// trace_recorder: captures register write-backs and stores into a time-stamped trace FIFO.
module trace_recorder
  import trace_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 2000,
  parameter int SKIP_X0    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [XLEN-1:0]        pc,
  input  logic                   reg_we,
  input  logic [4:0]             rd,
  input  logic [XLEN-1:0]        reg_wdata,
  input  logic                   mem_we,
  input  logic [XLEN-1:0]        mem_addr,
  input  logic [XLEN-1:0]        mem_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_kind,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_key,
  output logic [XLEN-1:0]        out_data,
  output logic [STAMP_W-1:0]     out_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            dropped,
  output logic                   timeout
);
  localparam int CW = $clog2(DEPTH) + 1;
  // same layout as trace_entry_t, widened to this instance's XLEN
  typedef struct packed {
    kind_e              kind;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    key;
    logic [XLEN-1:0]    data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;
  logic [STAMP_W-1:0] r_cyc;
  logic [15:0]        r_dropped;
  logic               r_timeout;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_free;
  logic               w_live;
  logic               w_reg_ev;
  logic               w_mem_ev;
  logic               w_pop;
  logic               w_push_reg;
  logic               w_push_mem;
  logic [16:0]        w_drop_sum;
  entry_t             w_reg_e;
  entry_t             w_mem_e;
  entry_t             w_head;
  // capture closes in the very cycle the counter passes the limit, one cycle before the flag
  assign w_live     = en && !r_timeout && (r_cyc <= STAMP_W'(MAX_CYCLES));
  assign w_reg_ev   = w_live && reg_we && !(SKIP_X0 != 0 && rd == 5'd0);
  assign w_mem_ev   = w_live && mem_we;
  assign w_pop      = out_valid && out_ready;
  assign w_free     = CW'(DEPTH) - w_count + CW'(w_pop);
  assign w_push_reg = w_reg_ev && (w_free != '0);
  assign w_push_mem = w_mem_ev && (w_free > CW'(w_push_reg));
  assign w_drop_sum = {1'b0, r_dropped} + 17'(w_reg_ev && !w_push_reg) + 17'(w_mem_ev && !w_push_mem);
  assign w_reg_e    = '{kind: KIND_REG, pc: pc, key: XLEN'(rd), data: reg_wdata, stamp: r_cyc};
  assign w_mem_e    = '{kind: KIND_MEM, pc: pc, key: mem_addr, data: mem_wdata, stamp: r_cyc};
  trace_fifo #(
    .DEPTH(DEPTH),
    .T    (entry_t)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push0(w_push_reg),
    .d0   (w_reg_e),
    .push1(w_push_mem),
    .d1   (w_mem_e),
    .pop  (w_pop),
    .head (w_head),
    .count(w_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc     <= '0;
      r_dropped <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cyc     <= (&r_cyc) ? r_cyc : r_cyc + 1'b1;
      r_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_timeout <= r_timeout || (r_cyc > STAMP_W'(MAX_CYCLES));
    end
  end
  assign count     = w_count;
  assign out_valid = (w_count != '0);
  assign out_kind  = w_head.kind;
  assign out_pc    = w_head.pc;
  assign out_key   = w_head.key;
  assign out_data  = w_head.data;
  assign out_stamp = w_head.stamp;
  assign dropped   = r_dropped;
  assign timeout   = r_timeout;
endmodule
